key_window_feeder: RTL and testbench
====================================

// Module: key_window_feeder
// PURPOSE
// - Upstream key source for the time-windowed locked FSMs (robm and siblings): holds NUM_KEYS key words
//   and drives the consumer's keyinput0..keyinputN bus with the word for the current counter window.
// - Keys are loaded over a valid/ready word interface, then committed. Until commit, an all-zero key is driven.
// - Keeps a free-running window counter aligned with the consumer's internal counter. Both share the reset net.
// PARAMETERS
// - KEY_W      12  bits per key word (= consumer keyinput count)
// - NUM_KEYS    4  key words per schedule (power of 2)
// - WINDOW     12  cycles per key window. Period = WINDOW*NUM_KEYS = 48.
// PORTS
// - clk          in   1        clock. Counter and state update on the falling edge, matching the consumer.
// - rst          in   1        reset, asynchronous, active-low. Top level drives the consumer's active-high rst with ~rst.
// - ld_valid     in   1        key word offered
// - ld_ready     out  1        key word accepted when ld_valid&&ld_ready at the edge
// - ld_idx       in   log2(NUM_KEYS)  key slot being written
// - ld_data      in   KEY_W    key word. ld_data[KEY_W-1] maps to keyinput0.
// - ld_commit    in   1        one-cycle pulse: arm the schedule
// - ld_clear     in   1        one-cycle pulse: wipe bank and disarm
// - key_out      out  KEY_W    to consumer. key_out[i] drives keyinput_i.
// - key_armed    out  1        schedule committed, real keys being driven
// - ld_err       out  1        one-cycle pulse: commit rejected (bank incomplete)
// BEHAVIOUR
// - Reset (rst=0, async):
//   - cnt=0, state=EMPTY, bank=0, written mask=0
//   - key_out=0, key_armed=0, ld_ready=1, ld_err=0
// - cnt: increments on every falling edge while out of reset, whatever the state.
//   - 0..WINDOW*NUM_KEYS-1, wraps to 0 after 47.
//   - This matches the consumer exactly: same reset release, same edge, same wrap.
// - win = cnt / WINDOW (0..3). Slot k covers cnt in [12k, 12k+11].
// - key_out = state==RUN ? bitrev(bank[win]) : 0.
//   - Combinational from registers, so it is stable across the consumer's sampling edge.
// - FSM (falling edge):
//   - EMPTY: accepted word -> LOADING
//   - LOADING:
//     - accepted words write bank[ld_idx] and set mask[ld_idx]; rewriting a slot overwrites it
//     - commit with mask all-ones -> RUN
//     - commit with any mask bit clear -> ld_err=1 for one cycle, stay LOADING
//   - RUN: ld_ready=0, words ignored, key_armed=1, commit ignored
//   - clear, in any state -> EMPTY: bank=0, mask=0. cnt is unaffected.
// - Priority on the same edge: clear > commit > write.
//   - A write on the commit edge is stored and counts toward the mask check.
// - ld_ready = (state != RUN). Transfer happens only when ld_valid&&ld_ready; no combinational path from ld_valid to ld_ready.
// - Commit takes effect at the next window boundary, not mid-window:
//   - RUN is entered at the edge where cnt wraps into a multiple of WINDOW
//   - until then, state=ARMING and key_out stays 0
//   - this prevents the consumer from seeing a partial window
// - Reset mid-operation clears everything asynchronously. The consumer resets on the same edge, so alignment is preserved.
// STRUCTURE
// - Shared package lock_key_pkg:
//   - KEY_W, NUM_KEYS, WINDOW, PERIOD=WINDOW*NUM_KEYS
//   - state enum {EMPTY, LOADING, ARMING, RUN}
//   - function bitrev
// - One sub-module, key_window_ctr: free-running modulo-PERIOD counter, outputs cnt, win, win_start.
//   The consumer's counter logic is a candidate to reuse it later.
// - Bank: NUM_KEYS x KEY_W flops plus NUM_KEYS mask bits. No RAM.
// TESTING
// - Reset, load words 2213, 58, 3451, 2484 into slots 0..3, commit:
//   - key_out=0 until the next cnt=0 or 12/24/36 boundary
//   - then the per-window words follow: cnt 0..11 -> bitrev(2213); cnt 12 -> 58; cnt 36..47 -> 2484; cnt 48 wraps -> 2213
// - Pair with robm, correct schedule: outputs match the unlocked golden FSM for 200 random cycles.
//   Same run with slot 2 = 3450: the FSM is forced to s4 in every cycle where cnt is 24..35.
// - Load only slots 0..2, pulse commit: ld_err=1 for exactly one cycle, key_armed stays 0, key_out stays 0.
// - Assert ld_valid in RUN: ld_ready=0 and the bank is unchanged. ld_clear in RUN -> next edge key_out=0, state EMPTY, cnt keeps counting.
// - Same-edge conflicts:
//   - clear+commit together -> EMPTY, no ld_err
//   - write of slot 3 on the commit edge -> commit accepted
// - Drop rst at cnt=30 in RUN, then release:
//   - all outputs are at reset values immediately
//   - after release, cnt restarts at 0 in lockstep with the consumer's counter (check over 100 cycles)

Source files
------------

// File: rtl/lock_key_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lock_key_pkg
// Purpose  : Shared sizes, FSM state encoding and helpers for the key window
//            feeder and its counter.
// Revision : 1.0  initial release
// ============================================================================
package lock_key_pkg;

  localparam int KEY_W    = 12;
  localparam int NUM_KEYS = 4;
  localparam int WINDOW   = 12;
  localparam int PERIOD   = WINDOW * NUM_KEYS;
  localparam int IDX_W    = $clog2(NUM_KEYS);
  localparam int CNT_W    = $clog2(PERIOD);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    ARMING  = 2'd2,
    RUN     = 2'd3
  } key_state_e;

  // The MSB of a stored word feeds keyinput0, so words are reversed on output.
  function automatic logic [KEY_W-1:0] bitrev(input logic [KEY_W-1:0] w);
    logic [KEY_W-1:0] r;
    for (int i = 0; i < KEY_W; i++) begin
      r[i] = w[KEY_W-1-i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_window_ctr.sv
`default_nettype none
// ============================================================================
// Module   : key_window_ctr
// Purpose  : Free-running modulo-PERIOD counter on the falling edge, with the
//            window index and a strobe marking the last cycle of a window.
// Revision : 1.0  initial release
// ============================================================================
module key_window_ctr
  import lock_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt_o,
  output logic [IDX_W-1:0] win_o,
  output logic             win_start_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: wrap after PERIOD-1 so the sequence matches the consumer.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CNT_W'(PERIOD - 1)) begin
      cnt_d = '0;
    end
  end

  // Counter register, falling edge to line up with the consumer.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign win_o       = IDX_W'(cnt_q / CNT_W'(WINDOW));
  // High in the last cycle of a window: the coming edge starts a new window.
  assign win_start_o = ((cnt_q % CNT_W'(WINDOW)) == CNT_W'(WINDOW - 1));

endmodule
`default_nettype wire

// File: rtl/key_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : key_window_feeder
// Purpose  : Holds a bank of key words loaded over valid/ready, and once the
//            schedule is committed drives the word for the current counter
//            window to the consumer's keyinput bus.
// Revision : 1.0  initial release
// ============================================================================
module key_window_feeder
  import lock_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [IDX_W-1:0] ld_idx,
  input  logic [KEY_W-1:0] ld_data,
  input  logic             ld_commit,
  input  logic             ld_clear,
  output logic [KEY_W-1:0] key_out,
  output logic             key_armed,
  output logic             ld_err
);

  key_state_e                     state_q, state_d;
  logic [NUM_KEYS-1:0][KEY_W-1:0] bank_q, bank_d;
  logic [NUM_KEYS-1:0]            mask_q, mask_d;
  logic                           err_q, err_d;

  logic                           w_xfer;
  logic [IDX_W-1:0]               w_win;
  logic                           w_win_start;
  // Raw count is not needed here; the window index and strobe carry everything.
  logic [CNT_W-1:0]               w_cnt_unused;

  key_window_ctr u_ctr (
    .clk         (clk),
    .rst         (rst),
    .cnt_o       (w_cnt_unused),
    .win_o       (w_win),
    .win_start_o (w_win_start)
  );

  assign w_xfer = ld_valid && (state_q != RUN);

  // Next state: clear beats commit, commit sees the word written on the same edge.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    mask_d  = mask_q;
    err_d   = 1'b0;

    if (ld_clear) begin
      state_d = EMPTY;
      bank_d  = '0;
      mask_d  = '0;
    end else begin
      if (w_xfer) begin
        bank_d[ld_idx] = ld_data;
        mask_d[ld_idx] = 1'b1;
      end

      unique case (state_q)
        EMPTY, LOADING: begin
          if (w_xfer) begin
            state_d = LOADING;
          end
          if (ld_commit) begin
            if (&mask_d) begin
              // Go live only on a window boundary so no partial window is seen.
              state_d = w_win_start ? RUN : ARMING;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ARMING: begin
          if (w_win_start) begin
            state_d = RUN;
          end
        end
        RUN: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State, bank and error registers; reset is asynchronous and shared with the consumer.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      bank_q  <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  assign ld_ready  = (state_q != RUN);
  assign key_armed = (state_q == RUN);
  assign ld_err    = err_q;
  assign key_out   = (state_q == RUN) ? bitrev(bank_q[w_win]) : '0;

endmodule
`default_nettype wire

// File: tb/tb_key_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_window_feeder
// Purpose  : Self-checking bench for key_window_feeder: a behavioural model
//            checked every cycle, plus hand-computed key words at known counts.
// Revision : 1.0  initial release
// ============================================================================
module tb_key_window_feeder;
  import lock_key_pkg::*;

  logic             clk;
  logic             rst;
  logic             ld_valid;
  logic             ld_ready;
  logic [IDX_W-1:0] ld_idx;
  logic [KEY_W-1:0] ld_data;
  logic             ld_commit;
  logic             ld_clear;
  logic [KEY_W-1:0] key_out;
  logic             key_armed;
  logic             ld_err;

  int n_checks = 0;
  int n_fail   = 0;

  key_window_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_idx    (ld_idx),
    .ld_data   (ld_data),
    .ld_commit (ld_commit),
    .ld_clear  (ld_clear),
    .key_out   (key_out),
    .key_armed (key_armed),
    .ld_err    (ld_err)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_cnt;
  bit m_run;
  bit m_pend;
  bit m_err;
  int m_bank [NUM_KEYS];
  bit m_wr   [NUM_KEYS];
  bit m_boundary;
  bit m_all;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt  = 0;
      m_run  = 0;
      m_pend = 0;
      m_err  = 0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        m_bank[i] = 0;
        m_wr[i]   = 0;
      end
    end else begin
      m_boundary = (((m_cnt + 1) % WINDOW) == 0);
      m_err = 0;
      if (ld_clear) begin
        m_run  = 0;
        m_pend = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
          m_bank[i] = 0;
          m_wr[i]   = 0;
        end
      end else begin
        if (ld_valid && !m_run) begin
          m_bank[ld_idx] = int'(ld_data);
          m_wr[ld_idx]   = 1;
        end
        if (m_pend) begin
          if (m_boundary) begin
            m_run  = 1;
            m_pend = 0;
          end
        end else if (ld_commit && !m_run) begin
          m_all = 1;
          for (int i = 0; i < NUM_KEYS; i++) if (!m_wr[i]) m_all = 0;
          if (!m_all)          m_err  = 1;
          else if (m_boundary) m_run  = 1;
          else                 m_pend = 1;
        end
      end
      m_cnt = (m_cnt + 1) % PERIOD;
    end
  end

  function automatic logic [KEY_W-1:0] exp_key();
    logic [KEY_W-1:0] w;
    logic [KEY_W-1:0] r;
    if (!m_run) return '0;
    w = KEY_W'(m_bank[m_cnt / WINDOW]);
    for (int i = 0; i < KEY_W; i++) r[KEY_W-1-i] = w[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the rising edge.
  always @(posedge clk) begin
    check("key_out",   32'(key_out),             32'(exp_key()));
    check("key_armed", 32'(key_armed),           32'(m_run));
    check("ld_ready",  32'(ld_ready),            32'(!m_run));
    check("ld_err",    32'(ld_err),              32'(m_err));
    check("cnt",       32'(dut.u_ctr.cnt_o),     32'(m_cnt));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input int idx, input int data, input bit commit);
    ld_valid  = 1'b1;
    ld_idx    = IDX_W'(idx);
    ld_data   = KEY_W'(data);
    ld_commit = commit;
    step();
    ld_valid  = 1'b0;
    ld_commit = 1'b0;
  endtask

  task automatic pulse(input bit commit, input bit clear);
    ld_commit = commit;
    ld_clear  = clear;
    step();
    ld_commit = 1'b0;
    ld_clear  = 1'b0;
  endtask

  task automatic wait_cnt(input int target);
    int n;
    n = 0;
    while (m_cnt != target && n < 2 * PERIOD) begin
      step();
      n++;
    end
    check("wait_cnt_timeout", 32'(m_cnt), 32'(target));
  endtask

  task automatic wait_armed();
    int n;
    n = 0;
    while (!key_armed && n < 2 * PERIOD) begin
      step();
      n++;
    end
    check("wait_armed_timeout", 32'(key_armed), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst       = 1'b0;
    ld_valid  = 1'b0;
    ld_idx    = '0;
    ld_data   = '0;
    ld_commit = 1'b0;
    ld_clear  = 1'b0;

    // Reset state
    run(2);
    check("rst_key_out",   32'(key_out),   32'h0);
    check("rst_key_armed", 32'(key_armed), 32'h0);
    check("rst_ld_ready",  32'(ld_ready),  32'h1);
    check("rst_ld_err",    32'(ld_err),    32'h0);
    rst = 1'b1;
    run(3);

    // Full schedule, then walk the windows
    load(0, 2213, 0);
    load(1, 58,   0);
    load(2, 3451, 0);
    load(3, 2484, 0);
    pulse(1'b1, 1'b0);
    wait_armed();
    wait_cnt(0);  check("win0_first", 32'(key_out), 32'hA51);
    wait_cnt(11); check("win0_last",  32'(key_out), 32'hA51);
    wait_cnt(12); check("win1_first", 32'(key_out), 32'h5C0);
    wait_cnt(24); check("win2_first", 32'(key_out), 32'hDEB);
    wait_cnt(36); check("win3_first", 32'(key_out), 32'h2D9);
    wait_cnt(47); check("win3_last",  32'(key_out), 32'h2D9);
    step();       check("wrap_win0",  32'(key_out), 32'hA51);

    // Words offered in RUN are refused and leave the bank alone
    ld_valid = 1'b1;
    ld_idx   = '0;
    ld_data  = '0;
    step();
    check("run_ld_ready", 32'(ld_ready), 32'h0);
    run(3);
    ld_valid = 1'b0;
    wait_cnt(0);  check("run_bank_kept", 32'(key_out), 32'hA51);

    // Asynchronous reset in the middle of RUN
    wait_cnt(30);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_key_out",   32'(key_out),   32'h0);
    check("mid_rst_key_armed", 32'(key_armed), 32'h0);
    check("mid_rst_ld_ready",  32'(ld_ready),  32'h1);
    check("mid_rst_cnt",       32'(dut.u_ctr.cnt_o), 32'h0);
    step();
    rst = 1'b1;
    run(100);

    // Incomplete bank: commit rejected for exactly one cycle
    load(0, 2213, 0);
    load(1, 58,   0);
    load(2, 3451, 0);
    pulse(1'b1, 1'b0);
    check("err_pulse",       32'(ld_err),    32'h1);
    check("err_not_armed",   32'(key_armed), 32'h0);
    step();
    check("err_one_cycle",   32'(ld_err),    32'h0);
    run(50);
    check("err_still_idle",  32'(key_out),   32'h0);

    // Last slot written on the commit edge still counts
    load(3, 2484, 1);
    check("same_edge_no_err", 32'(ld_err), 32'h0);
    wait_armed();
    wait_cnt(24); check("same_edge_win2", 32'(key_out), 32'hDEB);

    // Clear while running
    pulse(1'b0, 1'b1);
    check("clr_key_out",  32'(key_out),  32'h0);
    check("clr_ld_ready", 32'(ld_ready), 32'h1);
    run(20);

    // Clear and commit together on a full bank: clear wins, no error
    load(0, 2213, 0);
    load(1, 58,   0);
    load(2, 3450, 0);
    load(3, 2484, 0);
    pulse(1'b1, 1'b1);
    check("clr_commit_err", 32'(ld_err), 32'h0);
    run(60);
    check("clr_commit_idle", 32'(key_armed), 32'h0);

    // Altered slot 2 shows through in its window only
    load(0, 2213, 0);
    load(1, 58,   0);
    load(2, 3450, 0);
    load(3, 2484, 0);
    pulse(1'b1, 1'b0);
    wait_armed();
    wait_cnt(24); check("alt_win2", 32'(key_out), 32'h5EB);
    wait_cnt(12); check("alt_win1", 32'(key_out), 32'h5C0);
    run(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
